// File: rtl/id_stage_pipe_pkg.sv
// id_pkg: RV opcodes, ALU control codes, NOP word
// and the opcode -> instruction-format helper.
package id_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [6:0] F7_ALT = 7'b0100000;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  localparam logic [4:0] ALU_ADD   = 5'd0;
  localparam logic [4:0] ALU_SUB   = 5'd1;
  localparam logic [4:0] ALU_SLL   = 5'd2;
  localparam logic [4:0] ALU_SLT   = 5'd3;
  localparam logic [4:0] ALU_SLTU  = 5'd4;
  localparam logic [4:0] ALU_XOR   = 5'd5;
  localparam logic [4:0] ALU_SRL   = 5'd6;
  localparam logic [4:0] ALU_SRA   = 5'd7;
  localparam logic [4:0] ALU_OR    = 5'd8;
  localparam logic [4:0] ALU_AND   = 5'd9;
  localparam logic [4:0] ALU_LUI   = 5'd10;
  localparam logic [4:0] ALU_BEQ   = 5'd11;
  localparam logic [4:0] ALU_BNE   = 5'd12;
  localparam logic [4:0] ALU_BLT   = 5'd13;
  localparam logic [4:0] ALU_BGE   = 5'd14;
  localparam logic [4:0] ALU_BLTU  = 5'd15;
  localparam logic [4:0] ALU_BGEU  = 5'd16;
  localparam logic [4:0] ALU_JAL   = 5'd17;
  localparam logic [4:0] ALU_AUIPC = 5'd18;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J,
    FMT_X
  } fmt_e;

  function automatic fmt_e op_fmt(
    input logic [6:0] op
  );
    fmt_e f;
    unique case (op)
      OP_LUI, OP_AUIPC:         f = FMT_U;
      OP_JAL:                   f = FMT_J;
      OP_JALR, OP_LOAD, OP_IMM: f = FMT_I;
      OP_BRANCH:                f = FMT_B;
      OP_STORE:                 f = FMT_S;
      OP_REG:                   f = FMT_R;
      default:                  f = FMT_X;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/id_stage_pipe_alu_decoder.sv
// alu_decoder: opcode/func3/func7 -> ALU code, reg_we.
// Ports: opcode_i, func3_i, func7_i in; alu_ctrl_o, reg_we_o out.
module alu_decoder
  import id_pkg::*;
#(
  parameter int ALU_W = 5
) (
  input  logic [6:0]       opcode_i,
  input  logic [2:0]       func3_i,
  input  logic [6:0]       func7_i,
  output logic [ALU_W-1:0] alu_ctrl_o,
  output logic             reg_we_o
);

  logic       reg_op;
  logic [6:0] f7;
  logic       f7_zero;
  logic       f7_alt;
  logic [4:0] ar_code;
  logic       ar_ok;
  logic [4:0] code;
  logic       we;

  assign reg_op = (opcode_i == OP_REG);

  // OP-IMM shifts carry shamt[5] in bit 25 on RV64
  assign f7 = reg_op ? func7_i
                     : {func7_i[6:1], 1'b0};

  assign f7_zero = (f7 == 7'd0);
  assign f7_alt  = (f7 == F7_ALT);

  // Shared OP / OP-IMM table; func7 only
  // qualifies non-shift ops for register form.
  always_comb begin
    ar_code = ALU_ADD;
    ar_ok   = 1'b0;
    unique case (func3_i)
      3'b000: begin
        ar_code = (reg_op & f7_alt) ? ALU_SUB
                                    : ALU_ADD;
        ar_ok = !reg_op | f7_zero | f7_alt;
      end
      3'b001: begin
        ar_code = ALU_SLL;
        ar_ok   = f7_zero;
      end
      3'b010: begin
        ar_code = ALU_SLT;
        ar_ok   = !reg_op | f7_zero;
      end
      3'b011: begin
        ar_code = ALU_SLTU;
        ar_ok   = !reg_op | f7_zero;
      end
      3'b100: begin
        ar_code = ALU_XOR;
        ar_ok   = !reg_op | f7_zero;
      end
      3'b101: begin
        ar_code = f7_alt ? ALU_SRA : ALU_SRL;
        ar_ok   = f7_zero | f7_alt;
      end
      3'b110: begin
        ar_code = ALU_OR;
        ar_ok   = !reg_op | f7_zero;
      end
      3'b111: begin
        ar_code = ALU_AND;
        ar_ok   = !reg_op | f7_zero;
      end
      default: ;
    endcase
  end

  // Anything unrecognised falls out as ADD, no write.
  always_comb begin
    code = ALU_ADD;
    we   = 1'b0;
    unique case (opcode_i)
      OP_LUI: begin
        code = ALU_LUI;
        we   = 1'b1;
      end
      OP_AUIPC: begin
        code = ALU_AUIPC;
        we   = 1'b1;
      end
      OP_JAL: begin
        code = ALU_JAL;
        we   = 1'b1;
      end
      OP_JALR: begin
        if (func3_i == 3'b000) begin
          code = ALU_JAL;
          we   = 1'b1;
        end
      end
      OP_BRANCH: begin
        unique case (func3_i)
          3'b000:  code = ALU_BEQ;
          3'b001:  code = ALU_BNE;
          3'b100:  code = ALU_BLT;
          3'b101:  code = ALU_BGE;
          3'b110:  code = ALU_BLTU;
          3'b111:  code = ALU_BGEU;
          default: code = ALU_ADD;
        endcase
      end
      OP_LOAD: begin
        we = (func3_i != 3'b111);
      end
      OP_STORE: begin
        code = ALU_ADD;
      end
      OP_IMM, OP_REG: begin
        if (ar_ok) begin
          code = ar_code;
          we   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign alu_ctrl_o = ALU_W'(code);
  assign reg_we_o   = we;

endmodule

// File: rtl/id_stage_pipe.sv
// id_stage_pipe: decode stage + ID/EX register, IF/EX valid/ready.
// Ports: IF side (if_*), regfile (reg*), EX/MEM bypass (ex_*, mem_*),
// ID/EX outputs (id_*). Macro ID_FWD_EN enables EX/MEM forwarding;
// without it, any in-flight writer of a used rs stalls the stage.
module id_stage_pipe
  import id_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ALU_W  = 5,
  parameter int NREG_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              if_valid_i,
  output logic              if_ready_o,
  input  logic [XLEN-1:0]   if_pc_i,
  input  logic [31:0]       if_inst_i,
  output logic [NREG_W-1:0] reg1_raddr_o,
  output logic [NREG_W-1:0] reg2_raddr_o,
  input  logic [XLEN-1:0]   reg1_rdata_i,
  input  logic [XLEN-1:0]   reg2_rdata_i,
  input  logic              ex_reg_we_i,
  input  logic [NREG_W-1:0] ex_reg_waddr_i,
  input  logic              ex_is_load_i,
  input  logic [XLEN-1:0]   ex_result_i,
  input  logic              mem_reg_we_i,
  input  logic [NREG_W-1:0] mem_reg_waddr_i,
  input  logic [XLEN-1:0]   mem_result_i,
  input  logic              ex_ready_i,
  output logic              id_valid_o,
  output logic [XLEN-1:0]   id_pc_o,
  output logic [XLEN-1:0]   id_op_a_o,
  output logic [XLEN-1:0]   id_op_b_o,
  output logic [XLEN-1:0]   id_imm_o,
  output logic [NREG_W-1:0] id_reg_waddr_o,
  output logic [ALU_W-1:0]  id_ALUctrl_o,
  output logic              id_reg_we_o,
  output logic [31:0]       id_inst_o
);

  typedef struct packed {
    logic              valid;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   op_a;
    logic [XLEN-1:0]   op_b;
    logic [XLEN-1:0]   imm;
    logic [NREG_W-1:0] waddr;
    logic [ALU_W-1:0]  alu;
    logic              we;
    logic [31:0]       inst;
  } id_ex_t;

  id_ex_t ex_q;
  id_ex_t ex_d;

  logic [NREG_W-1:0] rs1;
  logic [NREG_W-1:0] rs2;
  logic [NREG_W-1:0] rd;
  fmt_e              fmt;
  logic              use_rs1;
  logic              use_rs2;

  assign rs1 = NREG_W'(if_inst_i[19:15]);
  assign rs2 = NREG_W'(if_inst_i[24:20]);
  assign rd  = NREG_W'(if_inst_i[11:7]);
  assign fmt = op_fmt(if_inst_i[6:0]);

  assign use_rs1 = fmt inside {FMT_R, FMT_I, FMT_S, FMT_B};
  assign use_rs2 = fmt inside {FMT_R, FMT_S, FMT_B};

  assign reg1_raddr_o = rs1;
  assign reg2_raddr_o = rs2;

  logic [ALU_W-1:0] dec_alu;
  logic             dec_we;

  alu_decoder #(
    .ALU_W(ALU_W)
  ) u_dec (
    .opcode_i   (if_inst_i[6:0]),
    .func3_i    (if_inst_i[14:12]),
    .func7_i    (if_inst_i[31:25]),
    .alu_ctrl_o (dec_alu),
    .reg_we_o   (dec_we)
  );

  // Immediate built at 32 bits, then sign-extended.
  logic signed [31:0] imm32;
  logic [XLEN-1:0]    imm_x;

  always_comb begin
    imm32 = '0;
    unique case (fmt)
      FMT_I: imm32 = {{20{if_inst_i[31]}},
                      if_inst_i[31:20]};
      FMT_S: imm32 = {{20{if_inst_i[31]}},
                      if_inst_i[31:25],
                      if_inst_i[11:7]};
      FMT_B: imm32 = {{19{if_inst_i[31]}},
                      if_inst_i[31],
                      if_inst_i[7],
                      if_inst_i[30:25],
                      if_inst_i[11:8],
                      1'b0};
      FMT_U: imm32 = {if_inst_i[31:12],
                      12'h000};
      FMT_J: imm32 = {{11{if_inst_i[31]}},
                      if_inst_i[31],
                      if_inst_i[19:12],
                      if_inst_i[20],
                      if_inst_i[30:21],
                      1'b0};
      default: imm32 = '0;
    endcase
  end

  assign imm_x = XLEN'(imm32);

  // Writer/source matches, x0 never matches.
  logic ex_m1;
  logic ex_m2;
  logic mem_m1;
  logic mem_m2;
  logic ex_wr;
  logic mem_wr;

  assign ex_wr  = ex_reg_we_i & (ex_reg_waddr_i != '0);
  assign mem_wr = mem_reg_we_i & (mem_reg_waddr_i != '0);
  assign ex_m1  = ex_wr & (ex_reg_waddr_i == rs1);
  assign ex_m2  = ex_wr & (ex_reg_waddr_i == rs2);
  assign mem_m1 = mem_wr & (mem_reg_waddr_i == rs1);
  assign mem_m2 = mem_wr & (mem_reg_waddr_i == rs2);

  logic            hazard;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;

`ifdef ID_FWD_EN
  // Only a load in EX cannot be bypassed yet.
  assign hazard = ex_is_load_i &
                  ((ex_m1 & use_rs1) |
                   (ex_m2 & use_rs2));

  always_comb begin
    op_a = reg1_rdata_i;
    if (rs1 == '0)
      op_a = '0;
    else if (ex_m1 & !ex_is_load_i)
      op_a = ex_result_i;
    else if (mem_m1)
      op_a = mem_result_i;
  end

  always_comb begin
    op_b = reg2_rdata_i;
    if (rs2 == '0)
      op_b = '0;
    else if (ex_m2 & !ex_is_load_i)
      op_b = ex_result_i;
    else if (mem_m2)
      op_b = mem_result_i;
  end
`else
  // No bypass: wait until every writer retires.
  assign hazard = ((ex_m1 | mem_m1) & use_rs1) |
                  ((ex_m2 | mem_m2) & use_rs2);

  assign op_a = reg1_rdata_i;
  assign op_b = reg2_rdata_i;

  logic unused_nofwd;
  assign unused_nofwd = ^{ex_is_load_i,
                          ex_result_i,
                          mem_result_i};
`endif

  logic slot_free;
  logic accept;

  assign slot_free  = !ex_q.valid | ex_ready_i;
  assign if_ready_o = slot_free & !hazard & !flush_i;
  assign accept     = if_valid_i & if_ready_o;

  always_comb begin
    ex_d = ex_q;
    if (flush_i) begin
      ex_d.valid = 1'b0;
      ex_d.we    = 1'b0;
    end else if (accept) begin
      ex_d.valid = 1'b1;
      ex_d.pc    = if_pc_i;
      ex_d.op_a  = op_a;
      ex_d.op_b  = op_b;
      ex_d.imm   = imm_x;
      ex_d.waddr = rd;
      ex_d.alu   = dec_alu;
      ex_d.we    = dec_we & (rd != '0);
      ex_d.inst  = if_inst_i;
    end else if (slot_free) begin
      ex_d.valid = 1'b0;
      ex_d.we    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q      <= '0;
      ex_q.inst <= NOP_INST;
    end else begin
      ex_q <= ex_d;
    end
  end

  assign id_valid_o     = ex_q.valid;
  assign id_pc_o        = ex_q.pc;
  assign id_op_a_o      = ex_q.op_a;
  assign id_op_b_o      = ex_q.op_b;
  assign id_imm_o       = ex_q.imm;
  assign id_reg_waddr_o = ex_q.waddr;
  assign id_ALUctrl_o   = ex_q.alu;
  assign id_reg_we_o    = ex_q.we;
  assign id_inst_o      = ex_q.inst;

endmodule

// File: tb/tb_id_stage_pipe.sv
// tb_id_stage_pipe: directed vector table plus hand sequences
// for load-use, hold, flush and mid-stall reset.
module tb_id_stage_pipe;
  import id_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic [4:0]  r1a;
  logic [4:0]  r2a;
  logic [31:0] r1d;
  logic [31:0] r2d;
  logic        ex_we;
  logic [4:0]  ex_wa;
  logic        ex_ld;
  logic [31:0] ex_res;
  logic        mem_we;
  logic [4:0]  mem_wa;
  logic [31:0] mem_res;
  logic        ex_ready;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_a;
  logic [31:0] id_b;
  logic [31:0] id_imm;
  logic [4:0]  id_wa;
  logic [4:0]  id_alu;
  logic        id_we;
  logic [31:0] id_inst;

  always #5 clk = ~clk;

  id_stage_pipe dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .flush_i         (flush),
    .if_valid_i      (if_valid),
    .if_ready_o      (if_ready),
    .if_pc_i         (if_pc),
    .if_inst_i       (if_inst),
    .reg1_raddr_o    (r1a),
    .reg2_raddr_o    (r2a),
    .reg1_rdata_i    (r1d),
    .reg2_rdata_i    (r2d),
    .ex_reg_we_i     (ex_we),
    .ex_reg_waddr_i  (ex_wa),
    .ex_is_load_i    (ex_ld),
    .ex_result_i     (ex_res),
    .mem_reg_we_i    (mem_we),
    .mem_reg_waddr_i (mem_wa),
    .mem_result_i    (mem_res),
    .ex_ready_i      (ex_ready),
    .id_valid_o      (id_valid),
    .id_pc_o         (id_pc),
    .id_op_a_o       (id_a),
    .id_op_b_o       (id_b),
    .id_imm_o        (id_imm),
    .id_reg_waddr_o  (id_wa),
    .id_ALUctrl_o    (id_alu),
    .id_reg_we_o     (id_we),
    .id_inst_o       (id_inst)
  );

  logic [31:0] rf [32];
  assign r1d = rf[r1a];
  assign r2d = rf[r2a];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string n,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h",
               n, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(
    input logic [6:0] f7, input logic [4:0] s2,
    input logic [4:0] s1, input logic [2:0] f3,
    input logic [4:0] d);
    return {f7, s2, s1, f3, d, 7'h33};
  endfunction

  function automatic logic [31:0] enc_i(
    input logic [11:0] im, input logic [4:0] s1,
    input logic [2:0] f3, input logic [4:0] d,
    input logic [6:0] op);
    return {im, s1, f3, d, op};
  endfunction

  function automatic logic [31:0] enc_s(
    input logic [11:0] im, input logic [4:0] s2,
    input logic [4:0] s1, input logic [2:0] f3);
    return {im[11:5], s2, s1, f3, im[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] enc_b(
    input logic [12:0] im, input logic [4:0] s2,
    input logic [4:0] s1, input logic [2:0] f3);
    return {im[12], im[10:5], s2, s1, f3,
            im[4:1], im[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_j(
    input logic [20:0] im, input logic [4:0] d);
    return {im[20], im[10:1], im[11],
            im[19:12], d, 7'h6F};
  endfunction

  typedef struct {
    string       name;
    logic        ifv;
    logic [31:0] inst;
    logic        exwe;
    logic [4:0]  exwa;
    logic        exld;
    logic [31:0] exres;
    logic        memwe;
    logic [4:0]  memwa;
    logic [31:0] memres;
    logic        rdy;
    logic        ops;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [4:0]  wa;
    logic [4:0]  alu;
    logic        we;
  } vec_t;

  vec_t vq[$];
  vec_t w;

  task automatic set_w(
    input logic exwe, input logic [4:0] exwa,
    input logic exld, input logic [31:0] exres,
    input logic memwe, input logic [4:0] memwa,
    input logic [31:0] memres);
    w.exwe = exwe;   w.exwa = exwa;
    w.exld = exld;   w.exres = exres;
    w.memwe = memwe; w.memwa = memwa;
    w.memres = memres;
  endtask

  task automatic add(
    input string n, input logic [31:0] inst,
    input logic rdy, input logic ops,
    input logic [31:0] a, input logic [31:0] b,
    input logic [31:0] imm, input logic [4:0] wa,
    input logic [4:0] alu, input logic we);
    vec_t v;
    v = w;
    v.name = n; v.ifv = 1'b1; v.inst = inst;
    v.rdy = rdy; v.ops = ops;
    v.a = a; v.b = b; v.imm = imm;
    v.wa = wa; v.alu = alu; v.we = we;
    vq.push_back(v);
    set_w(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic drv(input logic [31:0] inst,
                     input logic [31:0] pc);
    if_valid = 1'b1;
    if_inst  = inst;
    if_pc    = pc;
  endtask

  task automatic clr_w();
    ex_we = 0; ex_wa = 0; ex_ld = 0; ex_res = 0;
    mem_we = 0; mem_wa = 0; mem_res = 0;
  endtask

  logic [31:0] add3;
  logic [31:0] add6;
  logic [31:0] addi4;
  logic [31:0] sw2;
  logic [31:0] beq;
  logic [31:0] lui8;

  initial begin
    for (int i = 0; i < 32; i++)
      rf[i] = 32'(i) << 8;
    rf[1] = 32'd5;
    rf[2] = 32'd7;
    flush = 0; ex_ready = 1;
    if_valid = 0; if_inst = 0; if_pc = 0;
    clr_w();

    add3  = enc_r(7'h00, 2, 1, 3'd0, 3);
    add6  = enc_r(7'h00, 0, 5, 3'd0, 6);
    addi4 = enc_i(12'hFFF, 1, 3'd0, 4, 7'h13);
    sw2   = enc_s(12'hFFC, 2, 1, 3'd2);
    beq   = enc_b(13'h1FF8, 2, 1, 3'd0);
    lui8  = {20'h12345, 5'd8, 7'h37};

    set_w(0, 0, 0, 0, 0, 0, 0);
    add("add", add3, 1, 1, 5, 7, 0, 3, ALU_ADD, 1);
    add("sub", enc_r(7'h20, 2, 1, 3'd0, 7),
        1, 1, 5, 7, 0, 7, ALU_SUB, 1);
    add("sra", enc_r(7'h20, 2, 1, 3'd5, 9),
        1, 1, 5, 7, 0, 9, ALU_SRA, 1);
    add("addi", addi4, 1, 1, 5, 32'h1F00,
        32'hFFFF_FFFF, 4, ALU_ADD, 1);
    add("sw", sw2, 1, 1, 5, 7,
        32'hFFFF_FFFC, 28, ALU_ADD, 0);
    add("beq", beq, 1, 1, 5, 7,
        32'hFFFF_FFF8, 25, ALU_BEQ, 0);
    add("lui", lui8, 1, 0, 0, 0,
        32'h1234_5000, 8, ALU_LUI, 1);
    add("jal", enc_j(21'h1FFFFE, 1), 1, 0, 0, 0,
        32'hFFFF_FFFE, 1, ALU_JAL, 1);
    add("rd0", enc_r(7'h00, 2, 1, 3'd0, 0),
        1, 1, 5, 7, 0, 0, ALU_ADD, 0);
    add("illop", 32'hFFFF_FFFF, 1, 0, 0, 0,
        0, 31, ALU_ADD, 0);
    add("addix0", enc_i(12'd5, 0, 3'd0, 5, 7'h13),
        1, 1, 0, 32'h500, 5, 5, ALU_ADD, 1);
    add("lw", enc_i(12'd16, 1, 3'd2, 10, 7'h03),
        1, 1, 5, 32'h1000, 16, 10, ALU_ADD, 1);
    add("badf7", enc_r(7'h01, 2, 1, 3'd0, 3),
        1, 1, 5, 7, 0, 3, ALU_ADD, 0);
    add("noifv", add3, 1, 0, 0, 0, 0, 0, 0, 0);
    vq[vq.size()-1].ifv = 1'b0;

    set_w(1, 1, 0, 32'h100, 1, 1, 32'h200);
`ifdef ID_FWD_EN
    add("exwin", addi4, 1, 1, 32'h100, 32'h1F00,
        32'hFFFF_FFFF, 4, ALU_ADD, 1);
`else
    add("exwin", addi4, 0, 0, 0, 0, 0, 0, 0, 0);
`endif
    set_w(0, 0, 0, 0, 1, 2, 32'h200);
`ifdef ID_FWD_EN
    add("memfw", add3, 1, 1, 5, 32'h200,
        0, 3, ALU_ADD, 1);
`else
    add("memfw", add3, 0, 0, 0, 0, 0, 0, 0, 0);
`endif
    set_w(1, 5, 1, 32'hDEAD, 0, 0, 0);
    add("ldhaz", add6, 0, 0, 0, 0, 0, 0, 0, 0);
    set_w(1, 5, 1, 32'hDEAD, 0, 0, 0);
    add("ldnohaz", add3, 1, 1, 5, 7,
        0, 3, ALU_ADD, 1);
    set_w(1, 8, 0, 32'h111, 0, 0, 0);
    add("unorsuse", lui8, 1, 0, 0, 0,
        32'h1234_5000, 8, ALU_LUI, 1);
    set_w(1, 0, 1, 32'h111, 1, 0, 32'h222);
    add("x0src", enc_r(7'h00, 2, 0, 3'd0, 3),
        1, 1, 0, 7, 0, 3, ALU_ADD, 1);
    set_w(1, 2, 0, 32'h333, 0, 0, 0);
`ifdef ID_FWD_EN
    add("swfw", sw2, 1, 1, 5, 32'h333,
        32'hFFFF_FFFC, 28, ALU_ADD, 0);
`else
    add("swfw", sw2, 0, 0, 0, 0, 0, 0, 0, 0);
`endif
    set_w(1, 2, 1, 32'h333, 0, 0, 0);
    add("brhaz", beq, 0, 0, 0, 0, 0, 0, 0, 0);
    set_w(1, 9, 0, 32'h999, 1, 1, 32'h444);
`ifdef ID_FWD_EN
    add("memrs1", add3, 1, 1, 32'h444, 7,
        0, 3, ALU_ADD, 1);
`else
    add("memrs1", add3, 0, 0, 0, 0, 0, 0, 0, 0);
`endif
    set_w(0, 1, 0, 32'h555, 0, 0, 0);
    add("exwe0", add3, 1, 1, 5, 7,
        0, 3, ALU_ADD, 1);

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst.valid", id_valid, 0);
    chk("rst.we", id_we, 0);
    chk("rst.pc", id_pc, 0);
    chk("rst.a", id_a, 0);
    chk("rst.imm", id_imm, 0);
    chk("rst.alu", id_alu, 0);
    chk("rst.inst", id_inst, 32'h0000_0013);
    @(negedge clk);
    rst_n = 1;

    foreach (vq[k]) begin
      vec_t v;
      v = vq[k];
      @(negedge clk);
      if_valid = v.ifv;
      if_inst = v.inst;
      if_pc = 32'h1000 + 32'(k) * 4;
      ex_we = v.exwe; ex_wa = v.exwa;
      ex_ld = v.exld; ex_res = v.exres;
      mem_we = v.memwe; mem_wa = v.memwa;
      mem_res = v.memres;
      #1;
      chk($sformatf("%s.rdy", v.name),
          if_ready, v.rdy);
      @(posedge clk);
      #1;
      if (v.rdy && v.ifv) begin
        chk($sformatf("%s.valid", v.name), id_valid, 1);
        chk($sformatf("%s.pc", v.name), id_pc,
            32'h1000 + 32'(k) * 4);
        chk($sformatf("%s.imm", v.name), id_imm, v.imm);
        chk($sformatf("%s.wa", v.name), id_wa, v.wa);
        chk($sformatf("%s.alu", v.name), id_alu, v.alu);
        chk($sformatf("%s.we", v.name), id_we, v.we);
        chk($sformatf("%s.inst", v.name), id_inst, v.inst);
        if (v.ops) begin
          chk($sformatf("%s.a", v.name), id_a, v.a);
          chk($sformatf("%s.b", v.name), id_b, v.b);
        end
      end else begin
        chk($sformatf("%s.bvalid", v.name), id_valid, 0);
        chk($sformatf("%s.bwe", v.name), id_we, 0);
      end
    end

    // load-use: stall, bubble, then retry
    @(negedge clk);
    clr_w();
    ex_we = 1; ex_wa = 5; ex_ld = 1;
    drv(add6, 32'h1800);
    #1 chk("lu.rdy0", if_ready, 0);
    @(posedge clk); #1;
    chk("lu.bubble", id_valid, 0);
    @(negedge clk);
    clr_w();
    mem_we = 1; mem_wa = 5; mem_res = 32'hABC;
`ifdef ID_FWD_EN
    #1 chk("lu.rdy1", if_ready, 1);
    @(posedge clk); #1;
    chk("lu.valid", id_valid, 1);
    chk("lu.a", id_a, 32'hABC);
`else
    #1 chk("lu.rdy1", if_ready, 0);
    @(posedge clk); #1;
    chk("lu.bubble2", id_valid, 0);
    @(negedge clk);
    mem_we = 0;
    #1 chk("lu.rdy2", if_ready, 1);
    @(posedge clk); #1;
    chk("lu.valid", id_valid, 1);
    chk("lu.a", id_a, 32'h500);
`endif
    chk("lu.wa", id_wa, 6);

    // hold while EX is busy
    @(negedge clk);
    clr_w();
    drv(add3, 32'h2000);
    @(posedge clk); #1;
    chk("hold.load", id_valid, 1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      ex_ready = 0;
      rf[1] = 32'd99 + 32'(c);
      drv(enc_r(7'h20, 2, 1, 3'd0, 7),
          32'h2100 + 32'(c));
      #1 chk($sformatf("hold%0d.rdy", c), if_ready, 0);
      @(posedge clk); #1;
      chk($sformatf("hold%0d.valid", c), id_valid, 1);
      chk($sformatf("hold%0d.pc", c), id_pc, 32'h2000);
      chk($sformatf("hold%0d.a", c), id_a, 5);
      chk($sformatf("hold%0d.b", c), id_b, 7);
      chk($sformatf("hold%0d.wa", c), id_wa, 3);
      chk($sformatf("hold%0d.alu", c), id_alu, ALU_ADD);
      chk($sformatf("hold%0d.we", c), id_we, 1);
      chk($sformatf("hold%0d.inst", c), id_inst, add3);
    end
    rf[1] = 32'd5;

    // flush while held
    @(negedge clk);
    flush = 1;
    drv(addi4, 32'h2200);
    #1 chk("fl.rdy", if_ready, 0);
    @(posedge clk); #1;
    chk("fl.valid", id_valid, 0);
    chk("fl.we", id_we, 0);
    @(negedge clk);
    flush = 0; ex_ready = 1;
    drv(enc_r(7'h00, 2, 1, 3'd4, 11), 32'h2300);
    #1 chk("fl.rdy2", if_ready, 1);
    @(posedge clk); #1;
    chk("fl.next", id_valid, 1);
    chk("fl.pc", id_pc, 32'h2300);
    chk("fl.alu", id_alu, ALU_XOR);

    // async reset while stalled
    @(negedge clk);
    ex_ready = 0;
    drv(add3, 32'h2400);
    @(posedge clk); #3;
    rst_n = 0;
    #1;
    chk("ar.valid", id_valid, 0);
    chk("ar.we", id_we, 0);
    chk("ar.pc", id_pc, 0);
    chk("ar.inst", id_inst, 32'h0000_0013);
    @(negedge clk);
    ex_ready = 1;
    drv(add6, 32'h3000);
    rst_n = 1;
    #1 chk("ar.rdy", if_ready, 1);
    @(posedge clk); #1;
    chk("ar.acc", id_valid, 1);
    chk("ar.apc", id_pc, 32'h3000);
    chk("ar.a", id_a, 32'h500);

    @(negedge clk);
    if_valid = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
